// File: rtl/cond_pkg.sv
// Shared definitions for the input-conditioning blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cond_pkg;

    localparam int DEB_WIDTH_DEF  = 2;
    localparam int DEB_STABLE_DEF = 16;

    localparam int DEB_STABLE_MIN = 2;
    localparam int DEB_STABLE_MAX = 65535;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } debounce_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One channel: two-flop synchroniser, stability counter, registered level and edge pulses.
// Latency: dout/rise/fall update STABLE_CYCLES+1 edges after din is first captured.
// Backpressure: none; free-running, one sample per clock.
module debounce_chan
    import cond_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_DEF,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level has differed for STABLE_CYCLES samples: commit it.
                dout <= s2;
                cnt  <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    a_no_both_edges: assert property (@(posedge clk) disable iff (!rst_n) !(rise && fall));
    a_cnt_bound:     assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_LAST);

endmodule

// File: rtl/debounce_sync.sv
// Multi-channel synchronise-and-debounce front end feeding clean levels to the gate stage.
// Latency: STABLE_CYCLES+1 clocks from first capture of a new din level to dout/rise/fall.
// Backpressure: none; channels are independent and never stall.
module debounce_sync
    import cond_pkg::*;
#(
    parameter int WIDTH         = DEB_WIDTH_DEF,
    parameter int STABLE_CYCLES = DEB_STABLE_DEF,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (STABLE_CYCLES < DEB_STABLE_MIN || STABLE_CYCLES > DEB_STABLE_MAX) begin : g_bad_stable
        $error("debounce_sync: STABLE_CYCLES=%0d outside %0d..%0d",
               STABLE_CYCLES, DEB_STABLE_MIN, DEB_STABLE_MAX);
    end
    if (CNT_W != $clog2(STABLE_CYCLES)) begin : g_bad_cnt_w
        $error("debounce_sync: CNT_W is derived and must not be overridden");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din[i]),
            .dout  (dout[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule
